// File: rtl/jtobj_draw.sv
// jtobj_draw: sprite tile row drawer.
// Answers the object scanner's start/busy handshake. It fetches one 16-pixel,
// 4 bpp tile row from ROM in two 32-bit halves, applies the flips and the
// horizontal zoom, and streams the opaque pixels, tagged with their
// attribute, into the object line buffer at one output pixel per clock.

module jtobj_draw (
  input  logic        rst,
  input  logic        clk,
  input  logic        start,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [9:0]  hzoom,
  input  logic        hz_keep,
  output logic        busy,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [13:0] buf_data
);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    DRAW
  } state_t;

  state_t      state_q;

  // Per-tile parameters latched when a start request is accepted
  logic [9:0]  attr_q;
  logic        hflip_q;
  logic [8:0]  hpos_q;
  logic [9:0]  zoom_q;
  logic        keep_q;

  // Fetched tile row halves
  logic [31:0] pixLo_q;
  logic [31:0] pixHi_q;

  // Source accumulator (overflow, 4-bit integer, 6-bit fraction) and
  // destination X. Both survive the end of a tile so that a following
  // tile of the same sprite can carry on where this one stopped.
  logic [10:0] src_q;
  logic [8:0]  xpos_q;

  // Registered outputs
  logic        busy_q;
  logic [20:0] romAddr_q;
  logic        romCs_q;
  logic        bufWe_q;
  logic [8:0]  bufAddr_q;
  logic [13:0] bufData_q;

  // Combinational helpers for the pixel emitted this cycle
  logic [10:0] srcEntry_d;
  logic [8:0]  xposEntry_d;
  logic [10:0] curSrc_d;
  logic [8:0]  curX_d;
  logic [63:0] row_d;
  logic [3:0]  idx_d;
  logic [3:0]  pix_d;

  // Select the source position, destination X and pixel for this cycle.
  // The first pixel is emitted on the very cycle the second ROM half
  // arrives, so in that cycle the high half comes straight from rom_data
  // and the position comes from the tile-entry values.
  always_comb begin
    srcEntry_d  = keep_q ? {1'b0, src_q[9:0]} : 11'd0;
    xposEntry_d = keep_q ? xpos_q : hpos_q;
    if (state_q == DRAW) begin
      curSrc_d = src_q;
      curX_d   = xpos_q;
      row_d    = {pixHi_q, pixLo_q};
    end else begin
      curSrc_d = srcEntry_d;
      curX_d   = xposEntry_d;
      row_d    = {rom_data, pixLo_q};
    end
    idx_d = curSrc_d[9:6] ^ {4{hflip_q}};
    pix_d = row_d[{idx_d, 2'b00} +: 4];
  end

  // Drawing sequencer: fetch both halves, then step through the row at the
  // zoom rate until the accumulator overflows past the last source pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      attr_q    <= 10'd0;
      hflip_q   <= 1'b0;
      hpos_q    <= 9'd0;
      zoom_q    <= 10'd0;
      keep_q    <= 1'b0;
      pixLo_q   <= 32'd0;
      pixHi_q   <= 32'd0;
      src_q     <= 11'd0;
      xpos_q    <= 9'd0;
      busy_q    <= 1'b0;
      romAddr_q <= 21'd0;
      romCs_q   <= 1'b0;
      bufWe_q   <= 1'b0;
      bufAddr_q <= 9'd0;
      bufData_q <= 14'd0;
    end else begin
      case (state_q)
        IDLE: begin
          bufWe_q <= 1'b0;
          if (start) begin
            attr_q    <= attr;
            hflip_q   <= hflip;
            hpos_q    <= hpos;
            zoom_q    <= (hzoom < 10'd4) ? 10'd4 : hzoom;
            keep_q    <= hz_keep;
            romAddr_q <= {code, ysub ^ {4{vflip}}, 1'b0};
            romCs_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= REQ0;
          end
        end
        REQ0: begin
          state_q <= WAIT0;
        end
        WAIT0: begin
          if (rom_ok) begin
            pixLo_q   <= rom_data;
            romAddr_q <= {romAddr_q[20:1], 1'b1};
            state_q   <= REQ1;
          end
        end
        REQ1: begin
          state_q <= WAIT1;
        end
        WAIT1: begin
          if (rom_ok) begin
            pixHi_q   <= rom_data;
            romCs_q   <= 1'b0;
            bufWe_q   <= (pix_d != 4'd0);
            bufAddr_q <= curX_d;
            bufData_q <= {attr_q, pix_d};
            src_q     <= curSrc_d + {1'b0, zoom_q};
            xpos_q    <= curX_d + 9'd1;
            state_q   <= DRAW;
          end
        end
        DRAW: begin
          if (src_q[10]) begin
            bufWe_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            bufWe_q   <= (pix_d != 4'd0);
            bufAddr_q <= curX_d;
            bufData_q <= {attr_q, pix_d};
            src_q     <= curSrc_d + {1'b0, zoom_q};
            xpos_q    <= curX_d + 9'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          romCs_q <= 1'b0;
          bufWe_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign rom_addr = romAddr_q;
  assign rom_cs   = romCs_q;
  assign buf_we   = bufWe_q;
  assign buf_addr = bufAddr_q;
  assign buf_data = bufData_q;

endmodule
